// File: rtl/add_serial_digit.sv
// Digit-serial adder/subtractor: processes DIGIT bits of WIDTH-bit operands per
// clock through a DIGIT-bit ripple slice, with a registered carry between digits.
module add_serial_digit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned NDIG  = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // b_eff: operand B, already inverted for subtract
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             c_out_q;
  logic             ovf_q;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout;
  logic             last_dig;
  logic             capture;
  logic             step;

  assign a_dig    = a_q[cnt*DIGIT +: DIGIT];
  assign b_dig    = b_q[cnt*DIGIT +: DIGIT];
  assign last_dig = (cnt == CNT_W'(NDIG - 1));

  always_comb begin : ripple
    logic c;
    c          = carry_q;
    slice_sum  = '0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      slice_sum[i] = a_dig[i] ^ b_dig[i] ^ c;
      c            = (a_dig[i] & b_dig[i]) | (c & (a_dig[i] ^ b_dig[i]));
    end
    slice_cout = c;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    step      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (last_dig) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (capture) begin
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= sub ? ~c_in : c_in;
        cnt     <= '0;
      end
      if (step) begin
        sum_q[cnt*DIGIT +: DIGIT] <= slice_sum;
        carry_q                   <= slice_cout;
        cnt                       <= cnt + CNT_W'(1);
        // Flags are taken from the final slice so they are ready with done.
        if (last_dig) begin
          c_out_q <= slice_cout;
          ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                     (slice_sum[DIGIT-1] != a_q[WIDTH-1]);
        end
      end
    end
  end

  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_add_serial_digit.sv
// Scoreboard bench for add_serial_digit across several WIDTH/DIGIT configurations.
module tb_add_serial_digit;

  typedef struct {
    logic [15:0] sum;
    logic        c;
    logic        v;
    int          cap;
  } exp_t;

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        c;
    logic        v;
  } vec_t;

  logic clk;
  int   total   = 0;
  int   bad     = 0;
  int   fin_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nvec(int w);
    return (w == 16) ? 8 : 12;
  endfunction

  // Hand-computed vectors: {sub, a, b, c_in, sum, c_out, ovf}
  function automatic vec_t get_vec(int w, int i);
    vec_t t;
    t = '{1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0};
    if (w == 16) begin
      case (i)
        0: t = '{1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        1: t = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        2: t = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        3: t = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        4: t = '{1'b1, 16'h1234, 16'h4321, 1'b0, 16'hCF13, 1'b0, 1'b0};
        5: t = '{1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        6: t = '{1'b1, 16'h0010, 16'h0001, 1'b1, 16'h000E, 1'b1, 1'b0};
        default: t = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      endcase
    end else begin
      case (i)
        0:  t = '{1'b0, 16'h0F, 16'h01, 1'b0, 16'h10, 1'b0, 1'b0};
        1:  t = '{1'b0, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1, 1'b0};
        2:  t = '{1'b0, 16'h7F, 16'h01, 1'b0, 16'h80, 1'b0, 1'b1};
        3:  t = '{1'b1, 16'h05, 16'h07, 1'b0, 16'hFE, 1'b0, 1'b0};
        4:  t = '{1'b1, 16'h80, 16'h01, 1'b0, 16'h7F, 1'b1, 1'b1};
        5:  t = '{1'b1, 16'h10, 16'h01, 1'b1, 16'h0E, 1'b1, 1'b0};
        6:  t = '{1'b0, 16'hA5, 16'h5A, 1'b1, 16'h00, 1'b1, 1'b0};
        7:  t = '{1'b0, 16'h80, 16'h80, 1'b0, 16'h00, 1'b1, 1'b1};
        8:  t = '{1'b1, 16'h00, 16'h00, 1'b0, 16'h00, 1'b1, 1'b0};
        9:  t = '{1'b1, 16'h00, 16'h00, 1'b1, 16'hFF, 1'b0, 1'b0};
        10: t = '{1'b0, 16'h3C, 16'hC3, 1'b0, 16'hFF, 1'b0, 1'b0};
        default: t = '{1'b1, 16'h7F, 16'hFF, 1'b0, 16'h80, 1'b0, 1'b1};
      endcase
    end
    return t;
  endfunction

  for (genvar g = 0; g < 5; g++) begin : cfg
    localparam int unsigned W = (g == 4) ? 16 : 8;
    localparam int unsigned D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 8 : 4;
    localparam int unsigned N = W / D;

    logic         reset_b, start, sub, c_in;
    logic         busy, done, c_out, ovf;
    logic [W-1:0] a, b, sum;
    exp_t         q[$];
    int           cyc = 0;

    add_serial_digit #(.WIDTH(W), .DIGIT(D)) dut (
      .clk    (clk),
      .reset_b(reset_b),
      .start  (start),
      .sub    (sub),
      .a      (a),
      .b      (b),
      .c_in   (c_in),
      .busy   (busy),
      .done   (done),
      .sum    (sum),
      .c_out  (c_out),
      .ovf    (ovf)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL cfg%0d(W=%0d,D=%0d) %s: got %0h want %0h", g, W, D, nm, act, exp);
      end
    endtask

    // Independent reference: {ovf, c_out, sum} from full-width and signed arithmetic
    function automatic logic [W+1:0] model(input logic s, input logic [W-1:0] av,
                                           input logic [W-1:0] bv, input logic ci);
      logic [W:0]          full;
      logic signed [W-1:0] sav, sbv;
      longint              sa, sb, r;
      logic                v;
      full = {1'b0, av} + {1'b0, (s ? ~bv : bv)} + {{W{1'b0}}, ci ^ s};
      sav  = av;
      sbv  = bv;
      sa   = sav;
      sb   = sbv;
      r    = s ? (sa - sb - longint'(ci)) : (sa + sb + longint'(ci));
      v    = (r > ((longint'(1) << (W - 1)) - 1)) || (r < -(longint'(1) << (W - 1)));
      return {v, full[W], full[W-1:0]};
    endfunction

    task automatic run_op(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci, input logic [W-1:0] es, input logic ec,
                          input logic ev, input bit glitch);
      @(negedge clk);
      sub = s; a = av; b = bv; c_in = ci; start = 1'b1;
      q.push_back('{16'(es), ec, ev, cyc + 1});
      @(negedge clk);
      start = 1'b0;
      if (glitch) begin
        sub = ~s; a = ~av; b = bv + W'(1); c_in = ~ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      repeat (N + 2) @(negedge clk);
    endtask

    always @(negedge clk) begin
      if (reset_b && done) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL cfg%0d unexpected_done: got done=1 want no result pending", g);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sum", 32'(sum), 32'(e.sum[W-1:0]));
          chk("c_out", 32'(c_out), 32'(e.c));
          chk("ovf", 32'(ovf), 32'(e.v));
          chk("busy_at_done", 32'(busy), 32'd0);
          chk("latency", 32'(cyc - e.cap + 1), 32'(N + 1));
        end
      end
    end

    initial begin
      vec_t         t;
      logic [W+1:0] m;
      logic [W-1:0] ra, rb;
      logic         rs, rc;
      reset_b = 1'b0; start = 1'b0; sub = 1'b0; c_in = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'({busy, done, c_out, ovf, sum}), 32'd0);
      reset_b = 1'b1;

      for (int i = 0; i < nvec(W); i++) begin
        t = get_vec(W, i);
        run_op(t.sub, t.a[W-1:0], t.b[W-1:0], t.cin, t.s[W-1:0], t.c, t.v, (i % 3) == 0);
      end

      for (int i = 0; i < 6; i++) begin
        ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom); rc = 1'($urandom);
        m  = model(rs, ra, rb, rc);
        run_op(rs, ra, rb, rc, m[W-1:0], m[W], m[W+1], 1'b0);
      end

      // start held high: one capture every N+2 cycles, inputs scrambled in flight
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 4; i++) begin
        t = get_vec(W, i);
        sub = t.sub; a = t.a[W-1:0]; b = t.b[W-1:0]; c_in = t.cin;
        q.push_back('{t.s, t.c, t.v, cyc + 1});
        @(negedge clk);
        a = ~a; b = ~b; sub = ~sub;
        repeat (N + 1) @(negedge clk);
      end
      start = 1'b0;
      repeat (N + 2) @(negedge clk);

      // Abort mid-operation: outputs clear immediately and no result follows
      sub = 1'b0; a = W'(8'h3C); b = W'(8'h11); c_in = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (N > 1) @(negedge clk);
      reset_b = 1'b0;
      #1;
      chk("abort_outputs", 32'({busy, done, c_out, ovf, sum}), 32'd0);
      @(negedge clk);
      reset_b = 1'b1;
      repeat (N + 3) @(negedge clk);
      run_op(1'b0, W'(8'h0F), W'(8'h01), 1'b0, W'(8'h10), 1'b0, 1'b0, 1'b0);

      repeat (4) @(negedge clk);
      chk("results_drained", 32'(q.size()), 32'd0);
      fin_cnt++;
    end
  end

  initial begin
    for (int i = 0; i < 50000 && fin_cnt < 5; i++) @(posedge clk);
    if (fin_cnt < 5) begin
      total++;
      bad++;
      $display("FAIL timeout: finished configs %0d want 5", fin_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_serial_digit.md
Name: add_serial_digit

Overview:
- Parametrised sequential adder/subtractor and successor to the fixed 4-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, using a DIGIT-bit ripple slice and a registered carry between digits.
- Trades latency for area in datapaths where a full-width ripple adder is too large or too slow.
- Uses a start/done handshake and reports carry-out and signed overflow.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits processed per clock; 1 <= DIGIT <= WIDTH.
- NDIG, WIDTH/DIGIT (derived, not overridable), number of digit cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- reset_b  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = add, 1 = subtract; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- c_in  input  1  carry-in (add) or borrow-in (subtract); captured with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result is valid.
- sum  output  WIDTH  result; held until the next start.
- c_out  output  1  final carry; in subtract this is NOT-borrow.
- ovf  output  1  two's-complement overflow of the result.

Behaviour:
- Reset (reset_b low, asynchronous): state=IDLE; busy=0, done=0, sum=0, c_out=0, ovf=0; digit counter=0; operand registers=0.
- States are IDLE, RUN and DONE.
- IDLE:
  - start=1 at a clock edge captures a, sub, c_in, and b_eff = sub ? ~b : b.
  - The same edge sets the carry register to c0 = sub ? ~c_in : c_in, clears the counter, and enters RUN; busy=1 from the next cycle.
- RUN:
  - Each cycle adds digit k of A, digit k of b_eff and the carry register through a DIGIT-bit ripple slice.
  - The slice result is written into sum[k*DIGIT +: DIGIT] and its carry-out into the carry register; k increments.
  - Digit 0 is the LSB digit.
  - After digit NDIG-1, go to DONE.
- Sum update: sum bits not yet computed keep their previous value while busy. Checkers sample sum only at done.
- DONE (one cycle):
  - done=1, busy=0.
  - c_out = final carry.
  - ovf = (A[W-1] == b_eff[W-1]) && (sum[W-1] != A[W-1]).
  - Next state is IDLE.
- Latency: done asserts exactly NDIG+1 cycles after the edge that sampled start. With DIGIT=WIDTH the operation completes in one RUN cycle, so done appears 2 cycles after start.
- Arithmetic:
  - Add: {c_out,sum} = A + B + c_in.
  - Subtract: {c_out,sum} = A + ~B + ~c_in, i.e. sum = A - B - c_in mod 2^WIDTH.
  - c_out = 1 means no borrow.
- start while busy or in DONE: ignored; no queuing; operands are not recaptured.
- start held high continuously: a new operation begins in the cycle after done (IDLE samples it), giving throughput of one result per NDIG+2 cycles.
- Input changes after capture have no effect on the operation in flight.
- Reset mid-operation: immediate abort to the reset values; no done pulse. The next start after reset_b deasserts operates normally.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Basic add (WIDTH=8, DIGIT=2): a=0x0F, b=0x01, c_in=0, sub=0, start for 1 cycle -> done exactly 5 cycles later; sum=0x10, c_out=0, ovf=0; busy high for 4 cycles.
- Wrap-around add: a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, c_out=0, ovf=1.
- Subtract with borrow:
  - a=0x05, b=0x07, c_in=0, sub=1 -> sum=0xFE, c_out=0, ovf=0.
  - a=0x80, b=0x01, sub=1 -> sum=0x7F, c_out=1, ovf=1.
  - a=0x10, b=0x01, c_in=1, sub=1 -> sum=0x0E.
- Handshake robustness:
  - Pulse start again during RUN with different operands -> ignored; the first result is unchanged.
  - Hold start high -> back-to-back results, each done 6 cycles apart.
- Reset mid-operation: assert reset_b low on the 2nd RUN cycle -> all outputs 0 immediately and no done. A subsequent 0x0F+0x01 gives 0x10.
- Parameter sweep:
  - DIGIT=1, 2, 4, 8 with WIDTH=8, and DIGIT=4 with WIDTH=16.
  - Random operands/sub/c_in compared against a behavioural A±B±c_in reference.
  - Latency equals NDIG+1 in every configuration.
